// File: rtl/ram_port_arbiter.sv
// Two-client round-robin arbiter with optional lock, driving a 16x8 dual-port RAM.
// Registered command outputs; read data returns two cycles after grant with a client tag.
//
// state | meaning
// IDLE  | no ownership, normal round-robin arbitration
// OWN0  | client 0 granted with lock0 high; exclusive while lock0 stays high
// OWN1  | client 1 granted with lock1 high; exclusive while lock1 stays high
module ram_port_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;
    logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
    logic [ADDR_W-1:0] mem_raddr_q, mem_raddr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]        tag_vld_q, tag_vld_d;
    logic [1:0]        tag_id_q, tag_id_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              excl0, excl1;
    logic              grant_any, grant_id;
    logic              sel_wr, sel_lock;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Lock is honoured only while the owner keeps its lock input high.
    always_comb begin
        excl0     = (state_q == OWN0) && lock0;
        excl1     = (state_q == OWN1) && lock1;
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (excl0) begin
            grant_any = req0;
            grant_id  = 1'b0;
        end else if (excl1) begin
            grant_any = req1;
            grant_id  = 1'b1;
        end else if (req0 && req1) begin
            grant_any = 1'b1;
            grant_id  = ~last_q;
        end else if (req0) begin
            grant_any = 1'b1;
            grant_id  = 1'b0;
        end else if (req1) begin
            grant_any = 1'b1;
            grant_id  = 1'b1;
        end
    end

    always_comb begin
        sel_wr    = grant_id ? wr1    : wr0;
        sel_lock  = grant_id ? lock1  : lock0;
        sel_addr  = grant_id ? addr1  : addr0;
        sel_wdata = grant_id ? wdata1 : wdata0;
    end

    always_comb begin
        state_d = IDLE;
        last_d  = last_q;
        if (grant_any) begin
            last_d = grant_id;
            if (sel_lock) begin
                state_d = grant_id ? OWN1 : OWN0;
            end
        end else if ((excl0 || excl1) && (req0 || req1)) begin
            // owner is locked but momentarily idle while the other client waits
            state_d = state_q;
        end
    end

    always_comb begin
        gnt0_d      = grant_any && !grant_id;
        gnt1_d      = grant_any && grant_id;
        mem_we_d    = grant_any && sel_wr;
        mem_re_d    = grant_any && !sel_wr;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        mem_raddr_d = mem_raddr_q;
        if (grant_any && sel_wr) begin
            mem_waddr_d = sel_addr;
            mem_wdata_d = sel_wdata;
        end
        if (grant_any && !sel_wr) begin
            mem_raddr_d = sel_addr;
        end
        tag_vld_d = {tag_vld_q[0], grant_any && !sel_wr};
        tag_id_d  = {tag_id_q[0], grant_id};
        rvalid0_d = tag_vld_q[1] && !tag_id_q[1];
        rvalid1_d = tag_vld_q[1] && tag_id_q[1];
        rdata_d   = tag_vld_q[1] ? mem_rdata : rdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_raddr_q <= '0;
            mem_wdata_q <= '0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_waddr_q <= mem_waddr_d;
            mem_raddr_q <= mem_raddr_d;
            mem_wdata_q <= mem_wdata_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata_q     <= rdata_d;
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign rvalid0   = rvalid0_q;
    assign rvalid1   = rvalid1_q;
    assign rdata     = rdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_raddr = mem_raddr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter and sequencer for the 16x8 synchronous dual-port RAM (`ram_dual_port`). It accepts single-beat read/write requests from two clients, grants one per cycle using round-robin priority with an optional lock, and drives the RAM write and read ports from registered outputs. It returns read data to the issuing client with a tagged valid pulse. It sits between the client logic and the RAM instance.

## Interface
- ADDR_W, 4, RAM address width (16 locations)
- DATA_W, 8, RAM data width

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- req0, req1  in  1  client request; held high until the matching gnt
- wr0, wr1  in  1  1 = write, 0 = read; qualified by req
- lock0, lock1  in  1  keep ownership for the next request from the same client
- addr0, addr1  in  ADDR_W  request address
- wdata0, wdata1  in  DATA_W  write data
- gnt0, gnt1  out  1  one-cycle pulse: request accepted
- rvalid0, rvalid1  out  1  one-cycle pulse: rdata valid for that client
- rdata  out  DATA_W  read return data, shared by both clients
- mem_we, mem_re  out  1  RAM write and read enables
- mem_waddr, mem_raddr  out  ADDR_W  RAM addresses
- mem_wdata  out  DATA_W  RAM data_in
- mem_rdata  in  DATA_W  RAM data_out, valid after the edge that sampled mem_re

## Operation
- FSM states: IDLE, OWN0, OWN1. State updates every edge.
- In IDLE, or in OWNx with lockx low, a request is sampled at edge E0. Arbitration rule:
  - one requester -> it wins;
  - both requesting -> the winner is the one not granted last (pointer `last`, reset value 1, so client 0 wins first).
- In OWNx with lockx high, client x has exclusive grant. The other client is not granted, even if requesting.
- On a grant to x:
  - gntx = 1 for exactly one cycle;
  - `last` = x;
  - next state = OWNx if lockx is high, else IDLE.
- With no request, the next state is IDLE.
- When lockx drops in OWNx, the block returns to normal arbitration on that same edge.
- A write grant drives mem_we = 1, mem_waddr = addr, and mem_wdata = wdata for one cycle. mem_re = 0.
- A read grant drives mem_re = 1 and mem_raddr = addr for one cycle, and pushes tag x into a 2-deep shift pipeline.
- Read return: rdata is registered from mem_rdata, and rvalidx is asserted for the matching tag.
- The block never drives mem_we and mem_re high in the same cycle.
- Back-to-back grants (every cycle) are allowed. Reads and writes interleave freely.
- Request inputs are sampled only when req is high. wdata is ignored on reads.
- Reset (rst low, at any time):
  - all outputs go to 0 immediately: gnt*, rvalid*, rdata, mem_*;
  - state = IDLE, last = 1;
  - read-tag pipeline cleared, so in-flight reads never produce rvalid.

## Timing
- E0: request sampled. After E0: gntx and mem_* command are valid.
- E1: the RAM performs the access. After E1: mem_rdata is valid.
- E2: rdata is registered. After E2: rvalidx = 1 for one cycle.
- Latency:
  - gnt is 1 cycle after request;
  - rvalid is 2 cycles after gnt;
  - write data is in the RAM at the edge following gnt.
- Same-address read granted the cycle after a write returns the new data. The write happens at E1; the read is sampled at E2.
- Throughput: 1 transaction per cycle.
- Fairness: with both clients continuously requesting and unlocked, grants alternate 0,1,0,1.
- Deassertion of rst is synchronous to clk: the first arbitration happens at the first edge with rst high.

## Test plan
1. Reset, then client0 writes 0xA5 to addr 3; then client0 reads addr 3.
   - gnt0 pulses 1 cycle after req.
   - mem_we = 1 and mem_waddr = 3.
   - rvalid0 = 1 with rdata = 0xA5, 2 cycles after the read gnt.
2. Both clients request reads continuously (client0 addr 1, client1 addr 2) for 6 cycles.
   - gnt order: 0,1,0,1,0,1.
   - rvalid tags match that order; rdata matches the preloaded contents.
3. lock0 held high with req0 high for 4 requests while req1 is also high.
   - Four consecutive gnt0, no gnt1.
   - lock0 low -> gnt1 on the next arbitration.
4. Client0 writes addr 15 = 0x3C, and client1 reads addr 15 the next cycle.
   - rvalid1 with rdata = 0x3C.
   - Wrap: write all 16 addresses 0..15, then read them back; every value matches.
5. Assert rst low one cycle after a read gnt.
   - All outputs go to 0 immediately.
   - No rvalid appears after release.
   - The first post-reset simultaneous request is granted to client0.
